// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B, one bit per clock, LSB first.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-2:0]   res_r;
    logic [CW-1:0]      cnt_r;
    logic               br_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   d_r;
    logic               bout_r;
    logic [1:0]         cell_s;
    logic               diff_s;
    logic               br_next_s;
    logic [WIDTH-1:0]   full_s;
    logic               last_s;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
        full_sub = {((~a & b) | (~(a ^ b) & br)), (a ^ b ^ br)};
    endfunction

    // Shared full-subtractor cell and the assembled result including the current bit.
    always_comb begin
        cell_s    = full_sub(a_r[0], b_r[0], br_r);
        diff_s    = cell_s[0];
        br_next_s = cell_s[1];
        full_s    = {diff_s, res_r};
        last_s    = (cnt_r == LAST_CNT);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and status flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == SHIFT);
            done_r  <= (state_s == DONE);
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_sign_r;
    logic b_sign_r;
    logic ovf_r;

    // Operand sign bits captured at start and the overflow result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sign_r <= 1'b0;
            b_sign_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (state_r == IDLE && start) begin
            a_sign_r <= A[WIDTH-1];
            b_sign_r <= B[WIDTH-1];
        end else if (state_r == SHIFT && last_s) begin
            ovf_r <= (a_sign_r != b_sign_r) && (diff_s != a_sign_r);
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign Ovf = ovf_r;
`endif

    // Datapath: operand shift registers, borrow FF, bit counter and held results.
    // Results load on the last SHIFT edge so they are already valid during done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            cnt_r  <= '0;
            br_r   <= 1'b0;
            d_r    <= '0;
            bout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        res_r <= '0;
                        cnt_r <= '0;
                        br_r  <= 1'b0;
                    end else begin
                        a_r <= a_r;
                    end
                end
                SHIFT: begin
                    res_r <= full_s[WIDTH-1:1];
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    br_r  <= br_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        d_r    <= full_s;
                        bout_r <= br_next_s;
                    end else begin
                        d_r <= d_r;
                    end
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign D    = d_r;
    assign Bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a driver queues expected results from an
// arithmetic model, and a monitor compares them whenever done is presented.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;
`endif

    int total  = 0;
    int passed = 0;
    logic [W+1:0] exp_q[$];
    logic         prev_done = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: {ovf, borrow, difference} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ua;
        int ub;
        int sd;
        logic [W-1:0] d;
        logic bo;
        logic ov;
        ua = int'(a);
        ub = int'(b);
        sd = int'($signed(a)) - int'($signed(b));
        d  = W'((ua - ub + (1 << W)) % (1 << W));
        bo = (ua < ub);
        ov = (sd > ((1 << (W - 1)) - 1)) || (sd < -(1 << (W - 1)));
        return {ov, bo, d};
    endfunction

    // Monitor: pops the scoreboard on every done pulse and checks pulse width.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_n && done) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done with empty scoreboard, D=%0h", D);
            end else begin
                e = exp_q.pop_front();
                check("result_D", {24'd0, D}, {24'd0, e[W-1:0]});
                check("result_Bout", {31'd0, Bout}, {31'd0, e[W]});
`ifdef SERIAL_SUB_OVF_EN
                check("result_Ovf", {31'd0, Ovf}, {31'd0, e[W+1]});
`endif
            end
        end
        prev_done <= done;
    end

    // Issue one op from an IDLE negedge; ends at the following IDLE negedge.
    // inject: cycle at which a stray start is pulsed; abort: cycle at which rst_n drops.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, input int inject, input int abort);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        if (abort == 0) exp_q.push_back(model(a, b));
        #1;
        if (!hold) start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        for (int i = 1; i <= W + 2; i++) begin
            @(negedge clk);
            if (abort == i) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_done", {31'd0, done}, 32'd0);
                check("abort_D", {24'd0, D}, 32'd0);
                check("abort_Bout", {31'd0, Bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
                check("abort_Ovf", {31'd0, Ovf}, 32'd0);
`endif
                return;
            end
            check("busy_timing", {31'd0, busy}, {31'd0, (i <= W)});
            check("done_timing", {31'd0, done}, {31'd0, (i == W + 1)});
            if (inject == i) begin
                start = 1'b1;
                A = W'($urandom);
                B = W'($urandom);
            end else if (!hold) begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_D", {24'd0, D}, 32'd0);
        check("reset_Bout", {31'd0, Bout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h05, 8'h03, 1'b0, 0, 0);
        do_op(8'h03, 8'h05, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_D", {24'd0, D}, 32'h0000_00FE);
            check("hold_Bout", {31'd0, Bout}, 32'd1);
            check("hold_done", {31'd0, done}, 32'd0);
        end

        do_op(8'h80, 8'h01, 1'b0, 0, 0);
        do_op(8'hFF, 8'hFF, 1'b0, 0, 0);
        do_op(8'h00, 8'h01, 1'b0, 0, 0);
        do_op(8'h7F, 8'h80, 1'b0, 0, 0);

        // Stray start mid-operation must be dropped, not queued.
        do_op(8'h5A, 8'h33, 1'b0, 4, 0);
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            check("ignored_start_idle", {31'd0, busy}, 32'd0);
        end

        // Reset mid-SHIFT aborts without a done pulse.
        do_op(8'hC3, 8'h1E, 1'b0, 0, 5);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h10, 8'h01, 1'b0, 0, 0);

        for (int n = 0; n < 16; n++) begin
            do_op(W'($urandom), W'($urandom), 1'b0, 0, 0);
        end

        // Back-to-back with start held high.
        for (int n = 0; n < 4; n++) begin
            do_op(W'($urandom), W'($urandom), 1'b1, 0, 0);
        end
        start = 1'b0;

        repeat (W + 4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
